uart_rx_sequencer: RTL and testbench
====================================

// Module: uart_rx_sequencer
// PURPOSE
//  Receive-side controller for the 16x oversampling bit sample counter.
//  - Detects the start bit and enables/clears the counter.
//  - Consumes the counter's mid-bit (shift) and end-of-bit (strobe)
//    indications.
//  - Assembles an LSB-first frame, checks optional parity and stop
//    bit(s).
//  - Presents the byte on a valid/ack handshake.
// PARAMETERS
//  DATA_BITS   8  data bits per frame, 5..9
//  PARITY_EN   0  1 = one parity bit follows the data bits
//  PARITY_ODD  0  1 = odd parity, 0 = even (ignored if PARITY_EN=0)
//  STOP_BITS   1  stop bits checked, 1 or 2
// PORTS
//  clk         in   1          system clock, all logic on posedge
//  rst         in   1          synchronous reset, ACTIVE-LOW
//  sampleTick  in   1          16x baud enable, 1-cycle pulse
//  rxIn        in   1          serial line, already synchronised, idle=1
//  shiftIn     in   1          counter mid-bit indication (pulse or level)
//  strobeIn    in   1          counter end-of-bit indication (pulse or level)
//  cntEnable   out  1          counter enable
//  cntReset    out  1          counter reset, active-high
//  dataOut     out  DATA_BITS  received data, LSB = first bit on line
//  dataValid   out  1          dataOut holds an unacknowledged frame
//  dataAck     in   1          consumer accepts dataOut this cycle
//  parityErr   out  1          parity mismatch on the frame in dataOut
//  frameErr    out  1          stop bit sampled 0 on the frame in dataOut
//  overrun     out  1          frame completed while dataValid was already 1
//  busy        out  1          state != IDLE
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE.
//    - dataOut=0; dataValid, parityErr, frameErr, overrun, busy = 0.
//    - cntReset=1. Bit index and shift register cleared.
//    - Applies mid-frame too: the frame is discarded.
//  - shiftIn/strobeIn are rising-edge detected against a registered copy,
//    so a level-holding counter acts once per bit. midEv/endEv = those
//    edges. midEv and endEv never fall in the same cycle.
//  - cntEnable = sampleTick & (state in START,DATA,PARITY,STOP)
//    (combinational).
//  - cntReset is registered: 1 in IDLE and BREAK, 0 otherwise.
//  - FSM:
//    - IDLE:   rxIn 1->0 (registered prev) -> START.
//    - START:  midEv with rxIn=1 -> IDLE (false start, no output).
//              endEv -> DATA, bitIdx=0.
//    - DATA:   midEv: shift rxIn into MSB, shift right.
//              endEv at bitIdx==DATA_BITS-1 -> PARITY if PARITY_EN,
//              else STOP; otherwise bitIdx+1.
//    - PARITY: midEv: perr = (^data ^ rxIn ^ PARITY_ODD).
//              endEv -> STOP.
//    - STOP:   each midEv samples rxIn; ferr |= ~rxIn.
//              After midEv of stop bit STOP_BITS the frame completes:
//              -> IDLE, or -> BREAK if the last stop sample was 0.
//              Non-final stop bits advance on endEv.
//    - BREAK:  stay until rxIn==1 -> IDLE. No start detect while in BREAK.
//  - Completion (latency):
//    - Outputs update in the cycle after the final stop-bit midEv.
//    - dataOut/parityErr/frameErr load; dataValid=1.
//    - overrun=1 if dataValid was 1 and dataAck=0 in that same cycle.
//    - New data overwrites old.
//  - Handshake: dataAck while dataValid=1 clears dataValid, parityErr,
//    frameErr and overrun next cycle. Ack with dataValid=0 is ignored.
//    Completion together with ack: new frame loads, dataValid stays 1,
//    overrun=0.
//  - sampleTick low: the FSM holds; only counter events advance it.
// TESTING
//  - 8N1, send 0x55 (LSB first) -> dataValid=1 one cycle after stop
//    midEv, dataOut=0x55, perr=ferr=ovr=0; ack -> dataValid=0.
//  - rxIn low 4 ticks then high before first midEv -> back to IDLE,
//    cntReset=1, dataValid stays 0.
//  - 0xA3 with stop=0, rxIn held low 20 ticks -> dataOut=0xA3, frameErr=1,
//    state BREAK until rxIn=1, then a new frame is received.
//  - PARITY_EN=1 even, 0x07 with parity bit 0 -> parityErr=1;
//    parity bit 1 -> parityErr=0.
//  - 0x11 then 0x22 without ack -> dataOut=0x22, overrun=1; ack clears all
//    flags. Completion + ack same cycle -> overrun=0.
//  - rst=0 during DATA bit 3 -> next cycle all outputs at reset values,
//    cntReset=1; a following clean frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_sequencer_if.sv
// Received-byte bus: frame data and error flags from the sequencer, acknowledge from the consumer.
// Latency: wires only, no storage.
// Backpressure: dataValid holds until dataAck; a newer frame overwrites the old one and sets overrun.
// Ports: dataOut/dataValid/parityErr/frameErr/overrun (master drives), dataAck (slave drives).
interface uart_rx_sequencer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] dataOut;
    logic                 dataValid;
    logic                 dataAck;
    logic                 parityErr;
    logic                 frameErr;
    logic                 overrun;

    modport master (
        output dataOut, dataValid, parityErr, frameErr, overrun,
        input  dataAck
    );

    modport slave (
        input  dataOut, dataValid, parityErr, frameErr, overrun,
        output dataAck
    );
endinterface

// File: rtl/uart_rx_sequencer.sv
// UART receive sequencer: start detect, 16x bit-counter control, LSB-first frame assembly, parity/stop checks.
// Latency: received byte and flags are presented one cycle after the mid-bit event of the final stop bit.
// Backpressure: none on the line; an unacknowledged byte is overwritten by the next frame and overrun is flagged.
// Ports: clk, rst (sync, active-low); i_sampleTick, i_rxIn, i_shiftIn, i_strobeIn;
//        o_cntEnable, o_cntReset, o_busy; io_rx (master side of the received-byte bus).
module uart_rx_sequencer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sampleTick,
    input  logic                i_rxIn,
    input  logic                i_shiftIn,
    input  logic                i_strobeIn,
    output logic                o_cntEnable,
    output logic                o_cntReset,
    output logic                o_busy,
    uart_rx_sequencer_if.master io_rx
);

    localparam int             IW       = $clog2(DATA_BITS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic           ODD_BIT  = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state;
    logic                 r_cnt_reset;
    logic [IW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop_idx;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_rx_prev;
    logic                 r_shift_prev;
    logic                 r_strobe_prev;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_data_valid;
    logic                 r_parity_err;
    logic                 r_frame_err;
    logic                 r_overrun;

    // The counter may hold shift/strobe high for several cycles; act only on the rising edge.
    logic w_mid_ev;
    logic w_end_ev;
    logic w_last_stop;
    assign w_mid_ev    = i_shiftIn  & ~r_shift_prev;
    assign w_end_ev    = i_strobeIn & ~r_strobe_prev;
    assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;

    assign o_cntEnable = i_sampleTick & (r_state != S_IDLE) & (r_state != S_BREAK);
    assign o_cntReset  = r_cnt_reset;
    assign o_busy      = (r_state != S_IDLE);

    assign io_rx.dataOut   = r_data_out;
    assign io_rx.dataValid = r_data_valid;
    assign io_rx.parityErr = r_parity_err;
    assign io_rx.frameErr  = r_frame_err;
    assign io_rx.overrun   = r_overrun;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cnt_reset   <= 1'b1;
            r_bit_idx     <= '0;
            r_shift       <= '0;
            r_stop_idx    <= 1'b0;
            r_perr        <= 1'b0;
            r_ferr        <= 1'b0;
            r_rx_prev     <= 1'b1;
            r_shift_prev  <= 1'b0;
            r_strobe_prev <= 1'b0;
            r_data_out    <= '0;
            r_data_valid  <= 1'b0;
            r_parity_err  <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_rx_prev     <= i_rxIn;
            r_shift_prev  <= i_shiftIn;
            r_strobe_prev <= i_strobeIn;

            // Acknowledge retires the held byte; a completing frame below overrides this.
            if (r_data_valid && io_rx.dataAck) begin
                r_data_valid <= 1'b0;
                r_parity_err <= 1'b0;
                r_frame_err  <= 1'b0;
                r_overrun    <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_rx_prev && !i_rxIn) begin
                        r_state     <= S_START;
                        r_cnt_reset <= 1'b0;
                    end
                end
                S_START: begin
                    // Line back high at mid start bit is a glitch, not a frame.
                    if (w_mid_ev && i_rxIn) begin
                        r_state     <= S_IDLE;
                        r_cnt_reset <= 1'b1;
                    end else if (w_end_ev) begin
                        r_state    <= S_DATA;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_perr     <= 1'b0;
                        r_ferr     <= 1'b0;
                    end
                end
                S_DATA: begin
                    // Shift in at the MSB so the first bit ends up at bit 0.
                    if (w_mid_ev) begin
                        r_shift <= {i_rxIn, r_shift[DATA_BITS-1:1]};
                    end else if (w_end_ev) begin
                        if (r_bit_idx == LAST_IDX) begin
                            r_state <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_mid_ev) begin
                        r_perr <= (^r_shift) ^ i_rxIn ^ ODD_BIT;
                    end else if (w_end_ev) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_mid_ev) begin
                        if (w_last_stop) begin
                            r_data_out   <= r_shift;
                            r_parity_err <= r_perr;
                            r_frame_err  <= r_ferr | ~i_rxIn;
                            r_data_valid <= 1'b1;
                            r_overrun    <= r_data_valid & ~io_rx.dataAck;
                            r_cnt_reset  <= 1'b1;
                            // A low final stop sample means the line is held in break.
                            r_state      <= i_rxIn ? S_IDLE : S_BREAK;
                        end else begin
                            r_ferr <= r_ferr | ~i_rxIn;
                        end
                    end else if (w_end_ev && !w_last_stop) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                S_BREAK: begin
                    if (i_rxIn) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cnt_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: instance 0 is 8N1, instance 1 is 8E1.
// A bench-side counter emulation drives shift/strobe; a frame-level model predicts every output each cycle.
// Literal checks at the end of each scenario pin the model to hand-computed values.
`timescale 1ns/1ps
module tb_uart_rx_sequencer;

    localparam int M_IDLE  = 0;
    localparam int M_FRAME = 1;
    localparam int M_BRK   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic tick[2];
    logic line[2];
    logic shv[2];
    logic stv[2];
    logic ack[2];
    logic ack_on_mid[2];
    logic cen[2];
    logic crst[2];
    logic bsy[2];

    logic       d_valid[2];
    logic [7:0] d_data[2];
    logic       d_perr[2];
    logic       d_ferr[2];
    logic       d_ovr[2];

    uart_rx_sequencer_if #(.DATA_BITS(8)) if0 ();
    uart_rx_sequencer_if #(.DATA_BITS(8)) if1 ();

    assign if0.dataAck = ack[0];
    assign if1.dataAck = ack[1];
    assign d_valid[0] = if0.dataValid;
    assign d_valid[1] = if1.dataValid;
    assign d_data[0]  = if0.dataOut;
    assign d_data[1]  = if1.dataOut;
    assign d_perr[0]  = if0.parityErr;
    assign d_perr[1]  = if1.parityErr;
    assign d_ferr[0]  = if0.frameErr;
    assign d_ferr[1]  = if1.frameErr;
    assign d_ovr[0]   = if0.overrun;
    assign d_ovr[1]   = if1.overrun;

    uart_rx_sequencer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .i_sampleTick (tick[0]),
        .i_rxIn       (line[0]),
        .i_shiftIn    (shv[0]),
        .i_strobeIn   (stv[0]),
        .o_cntEnable  (cen[0]),
        .o_cntReset   (crst[0]),
        .o_busy       (bsy[0]),
        .io_rx        (if0.master)
    );

    uart_rx_sequencer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .i_sampleTick (tick[1]),
        .i_rxIn       (line[1]),
        .i_shiftIn    (shv[1]),
        .i_strobeIn   (stv[1]),
        .o_cntEnable  (cen[1]),
        .o_cntReset   (crst[1]),
        .o_busy       (bsy[1]),
        .io_rx        (if1.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic cmp8(input string nm, input int u, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] t=%0t got %h want %h", nm, u, $time, act, exp);
        end
    endtask

    task automatic cmp1(input string nm, input int u, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] t=%0t got %b want %b", nm, u, $time, act, exp);
        end
    endtask

    // Frame-level model: counts mid-bit events per frame, keeps the sampled line values,
    // and derives the byte and flags from them when the stop bit is sampled.
    int         m_ph[2];
    int         m_midn[2];
    logic [15:0] m_bits[2];
    logic       m_valid[2];
    logic [7:0] m_data[2];
    logic       m_perr[2];
    logic       m_ferr[2];
    logic       m_ovr[2];
    logic       m_prev_sh[2];
    logic       m_prev_line[2];

    task automatic model_step();
        for (int u = 0; u < 2; u++) begin
            logic       mid;
            logic       done;
            int         last;
            logic [7:0] d;
            last = 9 + ((u == 1) ? 1 : 0);
            done = 1'b0;
            if (!rst) begin
                m_ph[u]        = M_IDLE;
                m_midn[u]      = 0;
                m_bits[u]      = '0;
                m_valid[u]     = 1'b0;
                m_data[u]      = 8'h00;
                m_perr[u]      = 1'b0;
                m_ferr[u]      = 1'b0;
                m_ovr[u]       = 1'b0;
                m_prev_sh[u]   = 1'b0;
                m_prev_line[u] = 1'b1;
            end else begin
                mid = shv[u] && !m_prev_sh[u];
                case (m_ph[u])
                    M_IDLE: begin
                        if (m_prev_line[u] && !line[u]) begin
                            m_ph[u]   = M_FRAME;
                            m_midn[u] = 0;
                            m_bits[u] = '0;
                        end
                    end
                    M_FRAME: begin
                        if (mid) begin
                            if (m_midn[u] == 0 && line[u]) begin
                                m_ph[u] = M_IDLE;
                            end else begin
                                m_bits[u][m_midn[u]] = line[u];
                                if (m_midn[u] == last) done = 1'b1;
                                m_midn[u]++;
                            end
                        end
                    end
                    default: begin
                        if (line[u]) m_ph[u] = M_IDLE;
                    end
                endcase
                if (done) begin
                    d          = m_bits[u][8:1];
                    m_ovr[u]   = m_valid[u] && !ack[u];
                    m_valid[u] = 1'b1;
                    m_data[u]  = d;
                    m_perr[u]  = (u == 1) ? ((^d) ^ m_bits[u][9]) : 1'b0;
                    m_ferr[u]  = !line[u];
                    m_ph[u]    = line[u] ? M_IDLE : M_BRK;
                end else if (m_valid[u] && ack[u]) begin
                    m_valid[u] = 1'b0;
                    m_perr[u]  = 1'b0;
                    m_ferr[u]  = 1'b0;
                    m_ovr[u]   = 1'b0;
                end
                m_prev_sh[u]   = shv[u];
                m_prev_line[u] = line[u];
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                cmp1("dataValid", u, d_valid[u], m_valid[u]);
                cmp8("dataOut",   u, d_data[u],  m_data[u]);
                cmp1("parityErr", u, d_perr[u],  m_perr[u]);
                cmp1("frameErr",  u, d_ferr[u],  m_ferr[u]);
                cmp1("overrun",   u, d_ovr[u],   m_ovr[u]);
                cmp1("busy",      u, bsy[u],     m_ph[u] != M_IDLE);
                cmp1("cntReset",  u, crst[u],    m_ph[u] != M_FRAME);
                cmp1("cntEnable", u, cen[u],     tick[u] && (m_ph[u] == M_FRAME));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One bit time of a 16x counter: sample tick every other cycle, mid-bit at tick 8,
    // end-of-bit at tick 16 (pulse mode) or held levels (level mode).
    task automatic drive_bit(input int u, input logic v0, input logic v1, input int sw, input bit lvl);
        for (int t = 1; t <= 16; t++) begin
            line[u] = (t < sw) ? v0 : v1;
            tick[u] = 1'b1;
            if (lvl) begin
                shv[u] = (t >= 8 && t <= 11);
                stv[u] = (t >= 14);
            end else begin
                shv[u] = (t == 8);
                stv[u] = (t == 16);
            end
            ack[u] = (t == 8) ? ack_on_mid[u] : 1'b0;
            cyc();
            tick[u] = 1'b0;
            if (!lvl) begin
                shv[u] = 1'b0;
                stv[u] = 1'b0;
            end
            ack[u] = 1'b0;
            cyc();
        end
        shv[u] = 1'b0;
        stv[u] = 1'b0;
    endtask

    task automatic hold_line(input int u, input logic v, input int n);
        for (int t = 0; t < n; t++) begin
            line[u] = v;
            tick[u] = 1'b1;
            cyc();
            tick[u] = 1'b0;
            cyc();
        end
    endtask

    task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                              input logic stopv, input bit lvl, input logic ackl);
        drive_bit(u, 1'b0, 1'b0, 1, lvl);
        for (int i = 0; i < 8; i++) drive_bit(u, d[i], d[i], 1, lvl);
        if (u == 1) drive_bit(u, pbit, pbit, 1, lvl);
        ack_on_mid[u] = ackl;
        drive_bit(u, stopv, stopv, 1, lvl);
        ack_on_mid[u] = 1'b0;
    endtask

    task automatic ack_pulse(input int u);
        ack[u] = 1'b1;
        cyc();
        ack[u] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t bench did not finish", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            tick[u] = 1'b0; line[u] = 1'b1; shv[u] = 1'b0;
            stv[u] = 1'b0; ack[u] = 1'b0; ack_on_mid[u] = 1'b0;
        end
        cyc();
        chk_en = 1'b1;
        cmp1("rst_cntReset", 0, crst[0], 1'b1);
        cmp1("rst_valid",    0, d_valid[0], 1'b0);
        cmp1("rst_busy",     0, bsy[0], 1'b0);
        cmp8("rst_data",     0, d_data[0], 8'h00);
        cyc();
        rst = 1'b1;
        hold_line(0, 1'b1, 4);

        // 8N1 0x55
        send_frame(0, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0);
        cmp1("f55_valid", 0, d_valid[0], 1'b1);
        cmp8("f55_data",  0, d_data[0], 8'h55);
        cmp1("f55_perr",  0, d_perr[0], 1'b0);
        cmp1("f55_ferr",  0, d_ferr[0], 1'b0);
        cmp1("f55_ovr",   0, d_ovr[0], 1'b0);
        ack_pulse(0);
        cmp1("f55_ack_valid", 0, d_valid[0], 1'b0);

        // False start: low for 4 ticks, high again before mid-bit
        hold_line(0, 1'b1, 2);
        drive_bit(0, 1'b0, 1'b1, 5, 1'b0);
        hold_line(0, 1'b1, 4);
        cmp1("false_cntReset", 0, crst[0], 1'b1);
        cmp1("false_busy",     0, bsy[0], 1'b0);
        cmp1("false_valid",    0, d_valid[0], 1'b0);

        // 0xA3 with stop sampled low, line held in break
        send_frame(0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b0);
        hold_line(0, 1'b0, 20);
        cmp8("brk_data",     0, d_data[0], 8'hA3);
        cmp1("brk_ferr",     0, d_ferr[0], 1'b1);
        cmp1("brk_busy",     0, bsy[0], 1'b1);
        cmp1("brk_cntReset", 0, crst[0], 1'b1);
        ack_pulse(0);
        hold_line(0, 1'b1, 4);
        cmp1("brk_exit_busy", 0, bsy[0], 1'b0);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0);
        cmp8("after_brk_data", 0, d_data[0], 8'h5A);
        cmp1("after_brk_ferr", 0, d_ferr[0], 1'b0);
        ack_pulse(0);

        // Overrun: two frames without ack
        hold_line(0, 1'b1, 2);
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        hold_line(0, 1'b1, 2);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
        cmp8("ovr_data",  0, d_data[0], 8'h22);
        cmp1("ovr_flag",  0, d_ovr[0], 1'b1);
        cmp1("ovr_valid", 0, d_valid[0], 1'b1);
        ack_pulse(0);
        cmp1("ovr_ack_valid", 0, d_valid[0], 1'b0);
        cmp1("ovr_ack_flag",  0, d_ovr[0], 1'b0);

        // Completion coincident with ack of the previous byte
        hold_line(0, 1'b1, 2);
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
        hold_line(0, 1'b1, 2);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
        cmp1("cack_valid", 0, d_valid[0], 1'b1);
        cmp8("cack_data",  0, d_data[0], 8'h22);
        cmp1("cack_ovr",   0, d_ovr[0], 1'b0);

        // Reset during data bit 3 (held byte 0x22 is discarded too)
        hold_line(0, 1'b1, 2);
        drive_bit(0, 1'b0, 1'b0, 1, 1'b0);
        for (int i = 0; i < 3; i++) drive_bit(0, 1'b1, 1'b1, 1, 1'b0);
        hold_line(0, 1'b1, 5);
        cmp1("pre_rst_busy", 0, bsy[0], 1'b1);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        cmp1("mrst_cntReset", 0, crst[0], 1'b1);
        cmp1("mrst_busy",     0, bsy[0], 1'b0);
        cmp1("mrst_valid",    0, d_valid[0], 1'b0);
        cmp8("mrst_data",     0, d_data[0], 8'h00);
        hold_line(0, 1'b1, 4);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        cmp8("f3c_data",  0, d_data[0], 8'h3C);
        cmp1("f3c_valid", 0, d_valid[0], 1'b1);
        cmp1("f3c_ferr",  0, d_ferr[0], 1'b0);

        // 8E1: 0x07 has odd weight, so parity bit 0 is wrong and 1 is right
        hold_line(1, 1'b1, 2);
        send_frame(1, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
        cmp8("par0_data", 1, d_data[1], 8'h07);
        cmp1("par0_perr", 1, d_perr[1], 1'b1);
        ack_pulse(1);
        cmp1("par0_ack_perr", 1, d_perr[1], 1'b0);
        hold_line(1, 1'b1, 2);
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
        cmp8("par1_data",  1, d_data[1], 8'h07);
        cmp1("par1_perr",  1, d_perr[1], 1'b0);
        cmp1("par1_valid", 1, d_valid[1], 1'b1);
        hold_line(1, 1'b1, 2);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
